// File: rtl/op_issuer_if.sv
// Host-side and controller-side signal bundle for the matrix-controller
// operation issuer. The slave modport is the issuer's view; the master
// modport is the view of whatever drives commands and models the controller.
interface op_issuer_if;

  // Command port
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_word;

  // Serial load-data port
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;

  // Readback port
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;

  // Matrix-controller side
  logic [31:0] ctl_operation;
  logic [31:0] ctl_in_data;
  logic        ctl_enable;
  logic [31:0] ctl_out_data;

  modport slave (
    input  cmd_valid, cmd_word,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output ctl_operation, ctl_in_data, ctl_enable,
    input  ctl_out_data
  );

  modport master (
    output cmd_valid, cmd_word,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  ctl_operation, ctl_in_data, ctl_enable,
    output ctl_out_data
  );

endinterface

// File: rtl/op_issuer.sv
// Operation issuer for the matrix controller. Accepts one 32-bit operation
// word at a time, holds it on ctl_operation for as long as the operation
// needs (compute duration, load page, readback page), then drives opcode 0
// for GAP_CYC cycles so every new opcode reaches the controller as a fresh
// rising edge.
module op_issuer #(
  parameter int unsigned DRAIN_CYC = 24,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] size,
  op_issuer_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPUTE = 3'd1,
    LOAD    = 3'd2,
    READ    = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [13:0]        cnt;
  logic [13:0]        cnt_n;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_cnt_n;
  logic [31:0]        op_word;
  logic [9:0]         e_last;     // page elements minus one
  logic [13:0]        k_last;     // compute cycles minus one
  logic               done_n;
  logic               err_n;
  logic               accept;
  logic               legal;

  // Geometry decode from the live size input; only captured on accept, so
  // later changes to size while busy have no effect.
  logic [6:0]  nc;
  logic [3:0]  nl;
  logic [9:0]  e_calc;
  logic [13:0] k_calc;

  assign nc     = 7'(size[5:0]) + 7'd1;
  assign nl     = 4'(size[8:6]) + 4'd1;
  assign e_calc = 10'(nc) * 10'(nl);
  assign k_calc = 14'(e_calc) * 14'(nl) + 14'(DRAIN_CYC);

  assign legal  = (bus.cmd_word[3:0] == 4'd1) ||
                  (bus.cmd_word[3:0] == 4'd2) ||
                  (bus.cmd_word[3:0] == 4'd3);

  assign busy   = (state != IDLE);

  // State register, counters, latched command and status pulses.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      op_word <= '0;
      e_last  <= '0;
      k_last  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      gap_cnt <= gap_cnt_n;
      done    <= done_n;
      err     <= err_n;
      if (accept && legal) begin
        op_word <= bus.cmd_word;
        e_last  <= e_calc - 10'd1;
        k_last  <= k_calc - 14'd1;
      end
    end
  end

  // Next-state logic and all controller / host-facing outputs.
  // NOTE: every signal written here is given a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n           = state;
    cnt_n             = cnt;
    gap_cnt_n         = gap_cnt;
    done_n            = 1'b0;
    err_n             = 1'b0;
    accept            = 1'b0;
    bus.cmd_ready     = 1'b0;
    bus.wr_ready      = 1'b0;
    bus.rd_valid      = 1'b0;
    bus.rd_data       = '0;
    bus.ctl_operation = '0;
    bus.ctl_in_data   = '0;
    bus.ctl_enable    = 1'b1;

    unique case (state)
      IDLE: begin
        // Held low while reset is asserted so nothing is accepted then.
        bus.cmd_ready = reset;
        accept        = bus.cmd_valid && reset;
        if (accept) begin
          cnt_n = '0;
          unique case (bus.cmd_word[3:0])
            4'd1:    state_n = COMPUTE;
            4'd2:    state_n = LOAD;
            4'd3:    state_n = READ;
            default: err_n   = 1'b1;
          endcase
        end
      end

      COMPUTE: begin
        bus.ctl_operation = op_word;
        cnt_n             = cnt + 14'd1;
        if (cnt == k_last) begin
          state_n   = GAP;
          cnt_n     = '0;
          gap_cnt_n = '0;
        end
      end

      LOAD: begin
        // The controller only advances on beats the host actually supplies.
        bus.ctl_operation = op_word;
        bus.wr_ready      = 1'b1;
        bus.ctl_in_data   = bus.wr_data;
        bus.ctl_enable    = bus.wr_valid;
        if (bus.wr_valid) begin
          cnt_n = cnt + 14'd1;
          if (cnt == 14'(e_last)) begin
            state_n   = GAP;
            cnt_n     = '0;
            gap_cnt_n = '0;
          end
        end
      end

      READ: begin
        // A host stall freezes the controller's read pointer via enable.
        bus.ctl_operation = op_word;
        bus.rd_data       = bus.ctl_out_data;
        bus.rd_valid      = (cnt <= 14'(e_last));
        bus.ctl_enable    = bus.rd_ready;
        if (bus.rd_valid && bus.rd_ready) begin
          cnt_n = cnt + 14'd1;
          if (cnt == 14'(e_last)) begin
            state_n   = GAP;
            cnt_n     = '0;
            gap_cnt_n = '0;
          end
        end
      end

      GAP: begin
        gap_cnt_n = gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
          state_n   = IDLE;
          gap_cnt_n = '0;
          done_n    = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_op_issuer.sv
// Directed testbench for op_issuer. A tiny controller model returns its
// read address as out_data; each task drives one scenario and checks it.
module tb_op_issuer;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] size;
  logic       busy;
  logic       done;
  logic       err;

  int passed = 0;
  int total  = 0;

  op_issuer_if bus();

  op_issuer #(.DRAIN_CYC(24), .GAP_CYC(1)) dut (
    .clk   (clk),
    .reset (reset),
    .size  (size),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Controller read-pointer model: out_data equals the current address,
  // which advances on enabled cycles of opcode 3 and restarts otherwise.
  logic [31:0] rd_addr = '0;
  always @(posedge clk) begin
    if (bus.ctl_operation[3:0] != 4'd3) rd_addr <= '0;
    else if (bus.ctl_enable)            rd_addr <= rd_addr + 32'd1;
  end
  assign bus.ctl_out_data = rd_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    bus.cmd_word  = w;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = '0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!done && n < limit) begin
      step();
      n++;
    end
    total++;
    if (done !== 1'b1) $display("FAIL %s: done not seen within %0d cycles", name, limit);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_word = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    size = 9'b001_000011;
    step(); step();
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else passed++;
    total++; if (bus.ctl_operation !== 32'h0) $display("FAIL rst_op: got %h want 0", bus.ctl_operation); else passed++;
    total++; if (bus.ctl_in_data !== 32'h0) $display("FAIL rst_in_data: got %h want 0", bus.ctl_in_data); else passed++;
    total++; if (bus.ctl_enable !== 1'b1) $display("FAIL rst_enable: got %b want 1", bus.ctl_enable); else passed++;
    total++; if (bus.cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b want 0", bus.cmd_ready); else passed++;
    total++; if (bus.wr_ready !== 1'b0) $display("FAIL rst_wr_ready: got %b want 0", bus.wr_ready); else passed++;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %b want 0", bus.rd_valid); else passed++;
    total++; if (bus.rd_data !== 32'h0) $display("FAIL rst_rd_data: got %h want 0", bus.rd_data); else passed++;
    reset = 1'b1;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready: got %b want 1", bus.cmd_ready); else passed++;
    step();
  endtask

  task automatic test_illegal();
    issue(32'h0000_0005);
    total++; if (err !== 1'b1) $display("FAIL ill5_err: got %b want 1", err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ill5_busy: got %b want 0", busy); else passed++;
    total++; if (bus.ctl_operation !== 32'h0) $display("FAIL ill5_op: got %h want 0", bus.ctl_operation); else passed++;
    step();
    total++; if (err !== 1'b0) $display("FAIL ill5_err_pulse: got %b want 0", err); else passed++;
    issue(32'h0000_0000);
    total++; if (err !== 1'b1) $display("FAIL ill0_err: got %b want 1", err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ill0_busy: got %b want 0", busy); else passed++;
    total++; if (bus.ctl_operation !== 32'h0) $display("FAIL ill0_op: got %h want 0", bus.ctl_operation); else passed++;
    step();
    total++; if (err !== 1'b0) $display("FAIL ill0_err_pulse: got %b want 0", err); else passed++;
    total++; if (done !== 1'b0) $display("FAIL ill_done: got %b want 0", done); else passed++;
  endtask

  task automatic test_load();
    bit pat [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    int hs = 0;
    int stall_low = 0;
    int data_bad = 0;
    size = 9'b001_000011;  // NC=4, NL=2, E=8
    issue(32'h0000_0012);
    total++; if (bus.ctl_operation !== 32'h12) $display("FAIL load_op: got %h want 00000012", bus.ctl_operation); else passed++;
    for (int i = 0; i < 10; i++) begin
      bus.wr_valid = pat[i];
      bus.wr_data  = 32'hA0 + 32'(hs);
      #1;
      if (!pat[i] && !bus.ctl_enable) stall_low++;
      if (pat[i]) begin
        if (bus.ctl_in_data !== 32'hA0 + 32'(hs) || bus.ctl_enable !== 1'b1) data_bad++;
        if (bus.wr_ready) hs++;
      end
      step();
    end
    bus.wr_valid = 1'b0;
    total++; if (hs != 8) $display("FAIL load_handshakes: got %0d want 8", hs); else passed++;
    total++; if (stall_low != 2) $display("FAIL load_stall_enable_low: got %0d want 2", stall_low); else passed++;
    total++; if (data_bad != 0) $display("FAIL load_in_data: got %0d bad beats want 0", data_bad); else passed++;
    total++; if (bus.ctl_operation !== 32'h0) $display("FAIL load_gap_op: got %h want 0", bus.ctl_operation); else passed++;
    total++; if (bus.wr_ready !== 1'b0) $display("FAIL load_gap_wr_ready: got %b want 0", bus.wr_ready); else passed++;
    total++; if (done !== 1'b0) $display("FAIL load_gap_done: got %b want 0", done); else passed++;
    step();
    total++; if (done !== 1'b1) $display("FAIL load_done: got %b want 1", done); else passed++;
  endtask

  task automatic test_compute();
    int n = 0;
    int en_bad = 0;
    size = 9'b001_000011;
    issue(32'h0000_2101);
    while (bus.ctl_operation === 32'h2101 && n < 200) begin
      if (bus.ctl_enable !== 1'b1) en_bad++;
      n++;
      step();
    end
    total++; if (n != 40) $display("FAIL compute_len: got %0d cycles want 40", n); else passed++;
    total++; if (en_bad != 0) $display("FAIL compute_enable: got %0d low cycles want 0", en_bad); else passed++;
    total++; if (bus.ctl_operation !== 32'h0) $display("FAIL compute_gap_op: got %h want 0", bus.ctl_operation); else passed++;
    total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL compute_gap_state: got busy=%b done=%b want 1/0", busy, done); else passed++;
    step();
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL compute_done: got done=%b busy=%b want 1/0", done, busy); else passed++;
    step();
    total++; if (done !== 1'b0) $display("FAIL compute_done_pulse: got %b want 0", done); else passed++;
  endtask

  task automatic test_read();
    logic [31:0] got [8];
    int n = 0;
    int en_bad = 0;
    int cyc = 0;
    issue(32'h0000_0013);
    while (bus.rd_valid === 1'b1 && cyc < 40) begin
      bus.rd_ready = (cyc % 2 == 0);
      #1;
      if (bus.ctl_enable !== bus.rd_ready) en_bad++;
      if (bus.rd_ready) begin
        if (n < 8) got[n] = bus.rd_data;
        n++;
      end
      cyc++;
      step();
    end
    bus.rd_ready = 1'b0;
    total++; if (n != 8) $display("FAIL read_count: got %0d want 8", n); else passed++;
    total++; if (en_bad != 0) $display("FAIL read_enable_mirror: got %0d mismatches want 0", en_bad); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got[i] !== 32'(i)) $display("FAIL read_data[%0d]: got %h want %h", i, got[i], 32'(i));
      else passed++;
    end
    total++; if (bus.rd_valid !== 1'b0 || bus.ctl_operation !== 32'h0) $display("FAIL read_gap: got rd_valid=%b op=%h want 0/0", bus.rd_valid, bus.ctl_operation); else passed++;
    step();
    total++; if (done !== 1'b1) $display("FAIL read_done: got %b want 1", done); else passed++;
  endtask

  task automatic test_reset_mid_compute();
    int done_seen = 0;
    issue(32'h0000_2101);       // now in compute cycle 1
    repeat (4) step();          // compute cycle 5
    reset = 1'b0;
    step();
    total++; if (bus.ctl_operation !== 32'h0) $display("FAIL midrst_op: got %h want 0", bus.ctl_operation); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (done) done_seen++;
      step();
    end
    total++; if (done_seen != 0) $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); else passed++;
    issue(32'h0000_2101);
    total++; if (bus.ctl_operation !== 32'h2101 || busy !== 1'b1) $display("FAIL midrst_reaccept: got op=%h busy=%b want 00002101/1", bus.ctl_operation, busy); else passed++;
    wait_done("midrst_done", 100);
    step();
  endtask

  task automatic test_back_to_back();
    int zeros = 0;
    int cyc = 0;
    bit saw_load = 0;
    bit accepted = 0;
    logic acc_done = 1'b0;
    size = 9'b001_000011;
    bus.cmd_word  = 32'h0000_0012;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_word = 32'h0000_2101;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h55;
    while (!accepted && cyc < 100) begin
      if (bus.ctl_operation === 32'h12) saw_load = 1;
      else if (saw_load && bus.ctl_operation === 32'h0) zeros++;
      if (bus.cmd_ready === 1'b1) begin
        acc_done = done;
        accepted = 1;
      end
      step();
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    total++; if (!accepted) $display("FAIL b2b_accept: got no second accept within 100 cycles want accept"); else passed++;
    total++; if (acc_done !== 1'b1) $display("FAIL b2b_accept_on_done: got done=%b want 1", acc_done); else passed++;
    total++; if (!saw_load || zeros != 2) $display("FAIL b2b_zero_gap: got %0d zero cycles want 2", zeros); else passed++;
    total++; if (bus.ctl_operation !== 32'h2101) $display("FAIL b2b_second_op: got %h want 00002101", bus.ctl_operation); else passed++;
    wait_done("b2b_done", 100);
    step();
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_load();
    test_compute();
    test_read();
    test_reset_mid_compute();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
